// File: rtl/divu_unit_if.sv
// Divider request/response bundle: function code, operands, status and HI/LO/read-data.
// The master drives the operation; the slave, the divider, returns status and results.
interface divu_unit_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       Signal;
  logic             start;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] dout;

  modport master (
    output Signal, start, dataA, dataB,
    input  busy, done, hi, lo, dout
  );

  modport slave (
    input  Signal, start, dataA, dataB,
    output busy, done, hi, lo, dout
  );
endinterface

// File: rtl/divu_unit.sv
// Multi-cycle unsigned restoring divider (quotient->LO, remainder->HI), WIDTH iterations,
// done WIDTH edges after launch; no queueing, a launch outside IDLE is dropped and the pipe stalls on busy.
module divu_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  divu_unit_if.slave  div_if
);

  localparam logic [5:0]       OP_MFHI = 6'd16;
  localparam logic [5:0]       OP_MFLO = 6'd18;
  localparam logic [5:0]       OP_DIVU = 6'd27;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] dout_w;

  // One restoring step. A set top bit of the shifted remainder already exceeds
  // any WIDTH-bit divisor, so the subtraction cannot go negative in that case.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, div_q};
    trial_ok = rem_sh[WIDTH] | ~trial[WIDTH];
    if (trial_ok) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (div_if.start && (div_if.Signal == OP_DIVU)) begin
          state_d = S_BUSY;
          div_d   = div_if.dataB;
          quo_d   = div_if.dataA;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          hi_d    = rem_nx;
          lo_d    = quo_nx;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // MFHI/MFLO read path; during BUSY this shows the previous HI/LO.
  always_comb begin
    dout_w = '0;
    case (div_if.Signal)
      OP_MFHI: dout_w = hi_q;
      OP_MFLO: dout_w = lo_q;
      default: dout_w = '0;
    endcase
  end

  assign div_if.busy = (state_q == S_BUSY);
  assign div_if.done = (state_q == S_DONE);
  assign div_if.hi   = hi_q;
  assign div_if.lo   = lo_q;
  assign div_if.dout = dout_w;

endmodule

// File: tb/tb_divu_unit.sv
// Scoreboarded bench for divu_unit: directed corner cases, then random launches/reads
// checked against a plain-arithmetic division model.
module tb_divu_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divu_unit_if #(.WIDTH(W)) dif ();

  divu_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lc;
  } exp_t;

  exp_t         sb[$];
  int           cyc     = 0;
  int           n_vec   = 0;
  int           n_bad   = 0;
  int           next_ok = 0;
  logic [W-1:0] m_hi    = '0;
  logic [W-1:0] m_lo    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int lc);
    exp_t e;
    e.lc = lc;
    if (b == '0) begin
      e.lo = '1;
      e.hi = a;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: busy/done timing follows the outstanding launch; HI/LO must match the model at all times.
  always @(negedge clk) begin
    if (rst_n) begin
      logic eb, ed;
      exp_t e;
      eb = (sb.size() > 0) && ((cyc - sb[0].lc) < W);
      ed = (sb.size() > 0) && ((cyc - sb[0].lc) == W);
      check("busy", W'(dif.busy), W'(eb));
      check("done", W'(dif.done), W'(ed));
      if (ed) begin
        e    = sb.pop_front();
        m_hi = e.hi;
        m_lo = e.lo;
      end
      check("hi_reg", dif.hi, m_hi);
      check("lo_reg", dif.lo, m_lo);
    end
  end

  task automatic issue(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
    if (!now) @(negedge clk);
    dif.Signal = sig;
    dif.start  = 1'b1;
    dif.dataA  = a;
    dif.dataB  = b;
    @(posedge clk);
    #1;
    if (rst_n && sig == 6'd27 && cyc >= next_ok) begin
      sb.push_back(model(a, b, cyc));
      next_ok = cyc + W + 2;
    end
    dif.start  = 1'b0;
    dif.Signal = 6'd0;
  endtask

  // Returns 1 time unit after the negedge at which the result was popped.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done: result still pending after %0d cycles, expected 0 pending", 3 * W);
      sb.delete();
    end
  endtask

  task automatic check_dout(input logic [5:0] sig);
    logic [W-1:0] exp;
    @(negedge clk);
    dif.Signal = sig;
    dif.start  = 1'b0;
    #1;
    exp = (sig == 6'd16) ? m_hi : (sig == 6'd18) ? m_lo : '0;
    check("dout", dif.dout, exp);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", W'(dif.busy), '0);
    check("rst_done", W'(dif.done), '0);
    check("rst_hi", dif.hi, '0);
    check("rst_lo", dif.lo, '0);
    sb.delete();
    m_hi    = '0;
    m_lo    = '0;
    next_ok = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0]   sig;
    logic [W-1:0] a, b;
    int           r;

    rst_n      = 1'b0;
    dif.Signal = 6'd0;
    dif.start  = 1'b0;
    dif.dataA  = '0;
    dif.dataB  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(dif.busy), '0);
    check("reset_done", W'(dif.done), '0);
    check("reset_hi", dif.hi, '0);
    check("reset_lo", dif.lo, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic divide and read-back.
    issue(6'd27, 32'd100, 32'd7, 1'b0);
    wait_done();
    check("basic_lo", dif.lo, 32'd14);
    check("basic_hi", dif.hi, 32'd2);
    check_dout(6'd18);
    check_dout(6'd16);
    check_dout(6'd32);

    // Operand extremes and divide by zero.
    issue(6'd27, 32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done();
    check("max_lo", dif.lo, 32'hFFFF_FFFF);
    issue(6'd27, 32'd5, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    check("bigdiv_hi", dif.hi, 32'd5);
    issue(6'd27, 32'h1234, 32'd0, 1'b0);
    wait_done();
    check("dz_lo", dif.lo, 32'hFFFF_FFFF);
    check("dz_hi", dif.hi, 32'h1234);

    // Launch while busy is dropped; non-DIVU codes never launch.
    issue(6'd27, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    issue(6'd27, 32'd9, 32'd3, 1'b0);
    wait_done();
    check("ign_lo", dif.lo, 32'd14);
    check("ign_hi", dif.hi, 32'd2);
    repeat (40) @(posedge clk);
    issue(6'd32, 32'd8, 32'd2, 1'b0);
    repeat (5) @(posedge clk);

    // Asynchronous reset at iteration 10 abandons the division.
    issue(6'd27, 32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clk);
    mid_reset();
    repeat (40) @(posedge clk);
    issue(6'd27, 32'd100, 32'd7, 1'b0);
    wait_done();
    check("post_rst_lo", dif.lo, 32'd14);
    check("post_rst_hi", dif.hi, 32'd2);

    // Launch during the done cycle is ignored; the one in the following IDLE cycle is accepted.
    issue(6'd27, 32'd50, 32'd3, 1'b0);
    wait_done();
    issue(6'd27, 32'd81, 32'd9, 1'b1);
    issue(6'd27, 32'd81, 32'd9, 1'b0);
    wait_done();
    check("b2b_lo", dif.lo, 32'd9);
    check("b2b_hi", dif.hi, 32'd0);

    // Random launches and reads.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 2, 3: sig = 6'd27;
        4:          sig = 6'd16;
        5:          sig = 6'd18;
        6:          sig = 6'd32;
        default:    sig = 6'($urandom_range(0, 63));
      endcase
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) issue(sig, a, b, 1'b0);
      else                           check_dout(sig);
    end
    wait_done();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/divu_unit.md
Name: divu_unit

Overview:
- Multi-cycle unsigned divider with HI/LO result registers.
- Sits directly downstream of the ALU-control stage in the EX stage. Consumes its 6-bit divider function code (SignaltoDIV).
- DIVU starts a WIDTH-iteration restoring division. Quotient goes to LO, remainder to HI.
- MFHI/MFLO read HI/LO onto a result bus for the EX-stage result mux.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Signal  input  6  function code from ALU control (SignaltoDIV): DIVU=6'd27, MFHI=6'd16, MFLO=6'd18; all other codes are no-ops here.
- start  input  1  EX-stage instruction valid; qualifies Signal for DIVU launch.
- dataA  input  WIDTH  dividend (rs).
- dataB  input  WIDTH  divisor (rt).
- busy  output  1  high while a division is iterating; hazard unit stalls on it.
- done  output  1  one-cycle pulse when HI/LO are written.
- hi  output  WIDTH  HI register (remainder).
- lo  output  WIDTH  LO register (quotient).
- dout  output  WIDTH  read data for the result mux.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0; hi=0, lo=0.
  - Counter and working registers cleared.
  - An in-flight division is abandoned; HI/LO are not updated by it.
- States:
  - IDLE: waiting for a launch.
  - BUSY: iterating.
  - DONE: one cycle, done=1.
- IDLE -> BUSY:
  - At the rising edge where start=1 and Signal==27.
  - Latch divisor=dataB, quotient reg=dataA, partial remainder=0, count=0.
- BUSY iteration, one per edge:
  - {rem,quo} shifted left 1.
  - trial = rem_shifted - divisor, computed WIDTH+1 bits wide.
  - If trial non-negative: rem=trial[WIDTH-1:0], quo LSB=1. Otherwise rem=rem_shifted, quo LSB=0.
  - count increments by 1.
- BUSY -> DONE:
  - At the edge performing the final iteration (count==WIDTH-1).
  - At that same edge: lo=final quotient, hi=final remainder.
- DONE -> IDLE: unconditionally on the next edge.
- Latency and handshake:
  - Launch sampled at edge E0.
  - busy=1 from after E0 through the edge at E0+WIDTH.
  - done=1 and hi/lo valid from after edge E0+WIDTH, i.e. 32 edges for WIDTH=32.
  - busy and done are never high together.
- Launch filtering:
  - start with Signal==27 is ignored in BUSY and DONE; no queueing.
  - start with any other Signal never launches.
- Divide by zero is not trapped:
  - Natural restoring result: lo = all ones, hi = dataA.
  - Completes with normal latency.
- dout is combinational:
  - Signal==16 -> hi; Signal==18 -> lo; else 0.
  - It is independent of start and state.
  - During BUSY it shows the pre-division HI/LO. The stall on busy guarantees MFHI/MFLO never sample it then.
- HI/LO change only at the BUSY->DONE edge or on reset.
- A launch in the same cycle as done is impossible: state is DONE, so the launch is ignored.

Test Plan:
- Basic divide: launch DIVU with dataA=100, dataB=7. Expect:
  - busy high 32 cycles, then done pulse one cycle.
  - lo=14, hi=2.
  - Then Signal=18 -> dout=14; Signal=16 -> dout=2.
- Max operands: dataA=32'hFFFFFFFF, dataB=1 -> lo=32'hFFFFFFFF, hi=0. dataA=5, dataB=32'hFFFFFFFF -> lo=0, hi=5.
- Divide by zero: dataA=32'h1234, dataB=0 -> lo=32'hFFFFFFFF, hi=32'h1234, normal 32-cycle latency.
- Ignored launches:
  - While busy, re-assert start with Signal=27 and dataA=9, dataB=3. First result unchanged; no second busy period.
  - start with Signal=32 (ADD) never raises busy.
- Reset mid-operation:
  - Prior result hi=2/lo=14. Launch 1000/10, then pull rst_n low at iteration 10, asynchronously between edges.
  - Expect busy=0 immediately, hi=lo=0, done never pulses.
  - After release, a new 100/7 yields lo=14, hi=2.
- Back-to-back: launch in the IDLE cycle right after done. Accepted; second result (81/9 -> lo=9, hi=0) appears exactly 32 edges after its launch edge.
